// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: Moore FSM sequencing datapath enables,
// mux selects and AluOp per instruction; flags unsupported opcodes.
module mips_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH      = 4'd0;
  localparam logic [3:0] S_DECODE     = 4'd1;
  localparam logic [3:0] S_MEM_ADDR   = 4'd2;
  localparam logic [3:0] S_MEM_READ   = 4'd3;
  localparam logic [3:0] S_MEM_WB     = 4'd4;
  localparam logic [3:0] S_MEM_WRITE  = 4'd5;
  localparam logic [3:0] S_EXECUTE    = 4'd6;
  localparam logic [3:0] S_R_COMPLETE = 4'd7;
  localparam logic [3:0] S_BRANCH     = 4'd8;
  localparam logic [3:0] S_JUMP       = 4'd9;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       is_mem;
  logic       op_ok;

  assign is_mem = (Op == OP_LW) || (Op == OP_SW);
  assign op_ok  = is_mem || (Op == OP_RTYPE) ||
                  (Op == OP_BEQ) || (Op == OP_J);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem)              state_d = S_MEM_ADDR;
        else if (Op == OP_RTYPE) state_d = S_EXECUTE;
        else if (Op == OP_BEQ)   state_d = S_BRANCH;
        else if (Op == OP_J)     state_d = S_JUMP;
        else                     state_d = S_FETCH;
      end
      // Op is re-checked here so a corrupted IR falls back to fetch
      S_MEM_ADDR: begin
        if (Op == OP_LW)      state_d = S_MEM_READ;
        else if (Op == OP_SW) state_d = S_MEM_WRITE;
        else                  state_d = S_FETCH;
      end
      S_MEM_READ: state_d = S_MEM_WB;
      S_EXECUTE:  state_d = S_R_COMPLETE;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluOp       = 2'b00;
    PCSource    = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        AluSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE: AluSrcB = 2'b11;
      S_MEM_ADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        AluSrcA = 1'b1;
        AluOp   = 2'b10;
      end
      S_R_COMPLETE: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA     = 1'b1;
        AluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign Illegal = (state_q == S_DECODE) && !op_ok;
  assign State   = state_q;

endmodule
